// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and a helper that maps a state to its line level.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Level driven on the line while in a given state; data_bit is only used in DATA.
   function automatic logic line_level(input state_t st, input logic data_bit);
      logic lvl;
      lvl = IDLE_LEVEL;
      case (st)
         IDLE:    lvl = IDLE_LEVEL;
         START:   lvl = START_BIT;
         DATA:    lvl = data_bit;
         STOP:    lvl = STOP_BIT;
         default: lvl = IDLE_LEVEL;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/serial_frame_tx_baud.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last clock of each bit.
// restart holds the count at zero so a new frame always begins a full period.
module baud_tick_gen #(
   parameter int BAUD_DIV = 4
) (
   input  logic clock,
   input  logic clear,
   input  logic restart,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

   logic [15:0] count;

   // Free-running modulo-BAUD_DIV counter, zeroed by clear or restart.
   always_ff @(posedge clock) begin
      if (clear || restart) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 16'd1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB
// first, stop bit, each held BAUD_DIV clocks. The line idles high.
// sout is registered from the next-state line level, so the line changes on
// the same edge as the state and never glitches.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int BAUD_DIV = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             busy,
   output logic             sout,
   output logic             sout_bar,
   output logic             done
);

   localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [4:0]       bitcnt;
   logic [4:0]       bitcnt_next;
   logic             line_next;
   logic             done_next;
   logic             tick;
   logic             restart;

   // The bit timer is held at zero while idle, so the start bit gets a full period.
   assign restart = (state == IDLE);

   baud_tick_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clock   (clock),
      .clear   (clear),
      .restart (restart),
      .tick    (tick)
   );

   // Next-state, shift register, bit counter and next line level.
   always_comb begin
      state_next  = state;
      shreg_next  = shreg;
      bitcnt_next = bitcnt;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               state_next  = START;
               shreg_next  = data_in;
               bitcnt_next = '0;
            end
         end
         START: begin
            if (tick) begin
               state_next  = DATA;
               bitcnt_next = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_next = shreg >> 1;
               if (bitcnt == LAST_BIT) begin
                  state_next = STOP;
               end else begin
                  bitcnt_next = bitcnt + 5'd1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      line_next = line_level(state_next, shreg_next[0]);
   end

   // State and datapath registers; clear aborts any frame and forces the line high.
   always_ff @(posedge clock) begin
      if (clear) begin
         state    <= IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         sout     <= IDLE_LEVEL;
         sout_bar <= ~IDLE_LEVEL;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         shreg    <= shreg_next;
         bitcnt   <= bitcnt_next;
         sout     <= line_next;
         sout_bar <= ~line_next;
         done     <= done_next;
      end
   end

   assign ready = (state == IDLE);
   assign busy  = ~ready;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: two instances (8 bits / 4 clocks
// per bit, and 1 bit / 1 clock per bit) compared every cycle against a
// timeline model that derives the line from the frame's start time.
module tb_serial_frame_tx;

   localparam int W0 = 8;
   localparam int B0 = 4;
   localparam int W1 = 1;
   localparam int B1 = 1;

   logic          clock;
   logic          clear0, load0, clear1, load1;
   logic [W0-1:0] data0;
   logic [W1-1:0] data1;
   logic          rdy0, bsy0, so0, sb0, dn0;
   logic          rdy1, bsy1, so1, sb1, dn1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model state, one entry per instance
   bit          m_init [2];
   bit          m_act  [2];
   int          m_start[2];
   logic [15:0] m_word [2];
   bit          m_done [2];
   bit          e_sout [2];

   serial_frame_tx #(.WIDTH(W0), .BAUD_DIV(B0)) dut0 (
      .clock(clock), .clear(clear0), .load(load0), .data_in(data0),
      .ready(rdy0), .busy(bsy0), .sout(so0), .sout_bar(sb0), .done(dn0)
   );

   serial_frame_tx #(.WIDTH(W1), .BAUD_DIV(B1)) dut1 (
      .clock(clock), .clear(clear1), .load(load1), .data_in(data1),
      .ready(rdy1), .busy(bsy1), .sout(so1), .sout_bar(sb1), .done(dn1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   // Advance the model of instance i across one clock edge with the sampled inputs.
   task automatic model_edge(input int i, input logic c, input logic l, input logic [15:0] d);
      int  w, b, t, idx;
      bit  was_ready;
      w = (i == 0) ? W0 : W1;
      b = (i == 0) ? B0 : B1;
      was_ready = !m_act[i];
      m_done[i] = 1'b0;
      if (c) begin
         m_act[i]  = 1'b0;
         m_init[i] = 1'b1;
      end else begin
         if (m_act[i] && (cyc - m_start[i]) >= (w + 2) * b) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
         end
         if (was_ready && l) begin
            m_act[i]   = 1'b1;
            m_start[i] = cyc;
            m_word[i]  = d;
         end
      end
      if (m_act[i]) begin
         t   = cyc - m_start[i];
         idx = t / b;
         if (idx == 0)      e_sout[i] = 1'b0;
         else if (idx <= w) e_sout[i] = m_word[i][idx-1];
         else               e_sout[i] = 1'b1;
      end else begin
         e_sout[i] = 1'b1;
      end
   endtask

   // One clock: update model at the edge, then compare all outputs 1 time unit later.
   task automatic step();
      @(posedge clock);
      model_edge(0, clear0, load0, 16'(data0));
      model_edge(1, clear1, load1, 16'(data1));
      cyc++;
      #1;
      if (m_init[0]) begin
         check_eq("sout0",     so0,  e_sout[0]);
         check_eq("sout_bar0", sb0,  !e_sout[0]);
         check_eq("ready0",    rdy0, !m_act[0]);
         check_eq("busy0",     bsy0, m_act[0]);
         check_eq("done0",     dn0,  m_done[0]);
      end
      if (m_init[1]) begin
         check_eq("sout1",     so1,  e_sout[1]);
         check_eq("sout_bar1", sb1,  !e_sout[1]);
         check_eq("ready1",    rdy1, !m_act[1]);
         check_eq("busy1",     bsy1, m_act[1]);
         check_eq("done1",     dn1,  m_done[1]);
      end
   endtask

   task automatic wait_done0();
      int k;
      k = 0;
      while (!m_done[0] && k < 200) begin
         step();
         k++;
      end
      if (!m_done[0]) check_eq("done_wait0", 32'd0, 32'd1);
   endtask

   initial begin
      clear0 = 1'b1; load0 = 1'b1; data0 = 8'hFF;
      clear1 = 1'b1; load1 = 1'b1; data1 = 1'b1;
      repeat (3) step();

      // basic frame on both instances
      clear0 = 1'b0; clear1 = 1'b0;
      load0 = 1'b1; data0 = 8'hA5;
      load1 = 1'b1; data1 = 1'b1;
      step();
      load0 = 1'b0; data0 = 8'($urandom);
      load1 = 1'b0; data1 = 1'b0;
      repeat (9) step();

      // load while busy must be ignored
      load0 = 1'b1; data0 = 8'h00;
      step();
      load0 = 1'b0;
      wait_done0();

      // back-to-back: load in the done cycle
      load0 = 1'b1; data0 = 8'h3C;
      step();
      load0 = 1'b0; data0 = 8'hFF;
      wait_done0();
      repeat (2) step();

      // abort mid-frame, then a clean frame
      load0 = 1'b1; data0 = 8'h5A;
      step();
      load0 = 1'b0;
      repeat (14) step();
      clear0 = 1'b1;
      step();
      clear0 = 1'b0;
      repeat (2) step();
      load0 = 1'b1; data0 = 8'h81;
      step();
      load0 = 1'b0;
      wait_done0();
      step();

      // randomized traffic, including clear/load collisions
      for (int n = 0; n < 3000; n++) begin
         load0  = ($urandom_range(3) == 0);
         data0  = 8'($urandom);
         clear0 = ($urandom_range(199) == 0);
         load1  = ($urandom_range(2) == 0);
         data1  = 1'($urandom);
         clear1 = ($urandom_range(99) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
